// File: rtl/bus_fifo.sv
// Synchronous valid/ready FIFO with occupancy count, synchronous flush and a sticky
// overflow flag. Storage is a register array; pointers wrap modulo DEPTH (power of two).
module bus_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           flush,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, push, pop;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = mem_q[rptr_q];
  assign count     = count_q;
  assign ovf       = ovf_q;

  // Flush overrides both handshakes, including the storage write.
  assign push = in_valid & ~full & ~flush;
  assign pop  = out_ready & ~empty & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
      if (in_valid && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

endmodule

// File: tb/tb_bus_fifo.sv
// Self-checking bench for bus_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_bus_fifo;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             flush = 1'b0;
  logic [2:0]       count;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;

  bus_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, updating the reference model from the current inputs.
  task automatic step();
    bit do_push, do_pop;
    if (flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (in_valid && mq.size() == DEPTH) m_ovf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d in_ready=%b out_valid=%b ovf=%b, required 0 1 0 0",
               count, in_ready, out_valid, ovf);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      step();
    end
    idle_inputs();
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 5'h01) begin
      errors++;
      $display("FAIL fill: count=%0d in_ready=%b out_valid=%b out_data=%h, required 4 0 1 01",
               count, in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1;
    in_data  = 5'h1f;
    step();
    idle_inputs();
    checks++;
    if (ovf !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b count=%0d, required 1 4", ovf, count);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
        errors++;
        $display("FAIL overflow_drain: out_valid=%b out_data=%h, required 1 %h",
                 out_valid, out_data, WIDTH'(i));
      end
      step();
    end
    idle_inputs();
    checks++;
    if (ovf !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b count=%0d out_valid=%b, required 1 0 0",
               ovf, count, out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      in_valid = (k < 10);
      in_data  = WIDTH'(k);
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== WIDTH'(k - 1) || count > 3'd1) begin
          errors++;
          $display("FAIL wrap[%0d]: out_valid=%b out_data=%h count=%0d, required 1 %h <=1",
                   k, out_valid, out_data, count, WIDTH'(k - 1));
        end
      end
      step();
    end
    idle_inputs();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: count=%0d out_valid=%b, required 0 0", count, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(5'h10 + i);
      step();
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 5'h14;
    step();
    idle_inputs();
    checks++;
    if (count !== 3'd3 || out_data !== 5'h11) begin
      errors++;
      $display("FAIL simul_full: count=%0d out_data=%h, required 3 11", count, out_data);
    end
    out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b1;
    in_data  = 5'h15;
    step();
    idle_inputs();
    checks++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_data !== 5'h15) begin
      errors++;
      $display("FAIL simul_empty: count=%0d out_valid=%b out_data=%h, required 1 1 15",
               count, out_valid, out_data);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    in_data  = 5'h16;
    step();
    in_data  = 5'h17;
    step();
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: count=%0d, required 3", count);
    end
    flush    = 1'b1;
    in_data  = 5'h18;
    step();
    idle_inputs();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d out_valid=%b in_ready=%b ovf=%b, required 0 0 1 1",
               count, out_valid, in_ready, ovf);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = 5'h0a;
    step();
    in_data  = 5'h0b;
    step();
    idle_inputs();
    checks++;
    if (count !== 3'd2 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: count=%0d ovf=%b, required 2 1", count, ovf);
    end
    #2;
    rst_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset: count=%0d ovf=%b out_valid=%b in_ready=%b, required 0 0 0 1",
               count, ovf, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_post: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = WIDTH'($urandom);
      step();
      checks++;
      if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== (mq.size() != DEPTH) || ovf !== m_ovf ||
          (mq.size() != 0 && out_data !== mq[0])) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d out_valid=%b in_ready=%b ovf=%b out_data=%h, required %0d %b %b %b %h",
                 n, count, out_valid, in_ready, ovf, out_data, mq.size(), mq.size() != 0,
                 mq.size() != DEPTH, m_ovf, (mq.size() != 0) ? mq[0] : out_data);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_fifo.md
BUS_FIFO -- requirements
Module: bus_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 5: data bus width in bits; matches a 5-bit net bus [4:0].
REQ-002 SHALL have parameter DEPTH, default 4: number of storage entries; legal values are powers of two, 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream offers in_data.
REQ-006 SHALL have port in_ready, output, 1 bit: the FIFO accepts a word this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: the write word.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds the oldest stored word.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data, output, WIDTH bits: the head-of-queue word.
REQ-011 SHALL have port flush, input, 1 bit: synchronous clear of the contents.
REQ-012 SHALL have port count, output, clog2(DEPTH+1) bits: current occupancy.
REQ-013 SHALL have port ovf, output, 1 bit: sticky flag set by a push attempt while full.

Function
REQ-014 SHALL perform a push when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-015 SHALL perform a pop when out_valid=1 and out_ready=1 at a rising clk edge.
REQ-016 SHALL drive in_ready = (count != DEPTH), registered-state-derived only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0).
REQ-018 SHALL present out_data as the storage entry at the read pointer; its value when out_valid=0 is don't-care.
REQ-019 SHALL have a first-word latency of 1 cycle: a word pushed at edge N is visible with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-020 SHALL keep the read and write pointers at log2(DEPTH) bits, incrementing modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-021 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-022 SHALL, when simultaneous push and pop occur with count=DEPTH, ignore the push because in_ready=0; only the pop takes effect and count becomes DEPTH-1.
REQ-023 SHALL, when simultaneous push and pop occur with count=0, ignore the pop because out_valid=0; only the push takes effect and count becomes 1.
REQ-024 SHALL, when 0<count<DEPTH and push and pop are simultaneous, write at wptr, advance both pointers, and hold count.
REQ-025 SHALL, on in_valid=1 with count=DEPTH and flush=0 at an edge, set ovf=1 and leave storage, pointers and count unchanged.
REQ-026 SHALL hold ovf at 1 until reset; flush does not clear it.
REQ-027 SHALL, on flush=1 at an edge, set rptr=wptr=0 and count=0, overriding any push or pop that cycle; storage contents are not cleared.
REQ-028 SHALL never let data in storage change except by a push write.
REQ-029 SHALL preserve the word order exactly: no loss, duplication or reordering of accepted words.

Reset
REQ-030 SHALL, on rst_n=0, immediately (asynchronously) set rptr=0, wptr=0, count=0 and ovf=0, giving in_ready=1 and out_valid=0.
REQ-031 SHALL leave storage contents unreset.
REQ-032 SHALL discard all queued words when reset is asserted mid-operation; after release, out_valid=0 until a new push.
REQ-033 SHALL synchronise the rst_n deassertion externally; the block assumes release is clean relative to clk.

Verification
REQ-034 SHALL cover fill to full: push 0x01,0x02,0x03,0x04 with out_ready=0 -> count=4, in_ready=0, out_valid=1, out_data=0x01.
REQ-035 SHALL cover overflow: with the FIFO full, in_valid=1 for 1 cycle -> ovf=1, count stays 4; then pop 4 -> outputs 0x01..0x04 in order, ovf still 1.
REQ-036 SHALL cover wrap-around: 10 push/pop streaming cycles with data 0x00..0x09 and out_ready=1 -> outputs 0x00..0x09 in order, count never exceeds 1 after first push.
REQ-037 SHALL cover the simultaneous-event boundaries: at count=4 push+pop -> count=3; at count=0 push+pop -> count=1, out_data equals the pushed word.
REQ-038 SHALL cover flush: with count=3, flush=1 plus in_valid=1 -> count=0, out_valid=0, in_ready=1 next cycle, ovf unchanged.
REQ-039 SHALL cover async reset: rst_n=0 mid-clock with count=2 and ovf=1 -> count=0, ovf=0, out_valid=0 before the next clk edge.
